// File: rtl/fx_pkg.sv
// Purpose    : shared fixed-point types and constants for the mat_mult datapath (Q18.8, 27-bit).
// Latency    : n/a (package only).
// Backpressure: n/a.
// Contents   : FX_W/FX_FRAC widths, FX_MAX/FX_MIN saturation limits, fx_t, fxdiv_state_t,
//              and fx_mag(), the unsigned magnitude of a signed Q18.8 value.
package fx_pkg;

    localparam int FX_W    = 27;
    localparam int FX_FRAC = 8;

    typedef logic signed [FX_W-1:0] fx_t;

    localparam fx_t FX_MAX = 27'h3FFFFFF;
    localparam fx_t FX_MIN = 27'h4000000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } fxdiv_state_t;

    // Unsigned magnitude. The most negative value maps to 2^26, which an unsigned
    // FX_W-bit field still represents exactly, so no special case is needed.
    function automatic logic [FX_W-1:0] fx_mag(input fx_t v);
        logic [FX_W-1:0] m;
        m = v[FX_W-1] ? -v : v;
        return m;
    endfunction

endpackage

// File: rtl/fx_sat_round.sv
// Purpose    : round (half away from zero), apply sign and saturate an unsigned quotient to Q18.8.
// Latency    : combinational.
// Backpressure: none; pure function of its inputs.
// Ports      : q        - unsigned quotient magnitude, RB extra LSBs below the result LSB
//              neg      - result sign (sign_a ^ sign_b)
//              a_neg    - dividend sign, selects the divide-by-zero rail
//              dz       - divisor was zero; forces the rail value, no overflow
//              result   - signed Q18.8 output
//              overflow - magnitude exceeded the representable range and was clamped
module fx_sat_round
    import fx_pkg::*;
#(
    parameter int QW = FX_W + FX_FRAC,
    parameter int RB = 1
) (
    input  logic [QW+RB-1:0] q,
    input  logic             neg,
    input  logic             a_neg,
    input  logic             dz,
    output fx_t              result,
    output logic             overflow
);

    // Positive results may reach 2^26-1, negative ones 2^26 (two's complement asymmetry).
    localparam logic [QW:0] POS_LIM = (QW+1)'((64'd1 << (FX_W-1)) - 64'd1);
    localparam logic [QW:0] NEG_LIM = (QW+1)'(64'd1 << (FX_W-1));

    logic [QW:0] mag;

    generate
        if (RB != 0) begin : g_round
            // The extra quotient bit is the 0.5-LSB bit; adding it to the truncated
            // magnitude rounds half up on the magnitude, i.e. away from zero once signed.
            assign mag = (QW+1)'(q[QW+RB-1:RB]) + (QW+1)'(q[0]);
        end else begin : g_trunc
            assign mag = {1'b0, q};
        end
    endgenerate

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        if (dz) begin
            result = a_neg ? FX_MIN : FX_MAX;
        end else if (!neg) begin
            if (mag > POS_LIM) begin
                result   = FX_MAX;
                overflow = 1'b1;
            end else begin
                result = fx_t'(mag[FX_W-1:0]);
            end
        end else begin
            if (mag > NEG_LIM) begin
                result   = FX_MIN;
                overflow = 1'b1;
            end else begin
                // -2^26 wraps onto itself in FX_W bits, which is the correct encoding.
                result = fx_t'(-mag[FX_W-1:0]);
            end
        end
    end

endmodule

// File: rtl/fx_div_27.sv
// Purpose    : iterative signed Q18.8 divider, result = (dataa << 8) / datab, restoring radix-2.
// Latency    : accept at edge T -> out_valid after edge T+ITER+2 (38 enabled cycles, 37 without rounding).
// Backpressure: single operation in flight; result/flags held in DONE until out_ready; en=0 freezes all.
// Ports      : clk, rst_n (async active-low), en (clock enable)
//              in_valid/in_ready, dataa/datab (Q18.8 dividend/divisor)
//              out_valid/out_ready, result (Q18.8), div_zero, overflow (qualified by out_valid)
// Config     : define FXDIV_ROUND_EN for round-half-away-from-zero (36 iterations);
//              undefined gives truncation toward zero (35 iterations).
module fx_div_27
    import fx_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [FX_W-1:0] dataa,
    input  logic [FX_W-1:0] datab,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FX_W-1:0] result,
    output logic            div_zero,
    output logic            overflow
);

    localparam int W     = FX_W;
    localparam int FRAC  = FX_FRAC;
    localparam int QBITS = W + FRAC;
`ifdef FXDIV_ROUND_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif
    localparam int ITER = QBITS + RB;
    localparam int CW   = $clog2(ITER + 1);
    localparam logic [CW-1:0] LAST = CW'(ITER);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_CALC = CALC;
    localparam logic [1:0] S_FIX  = FIX;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]      state;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    dvs;      // |datab|
    logic [W-1:0]    rem;      // partial remainder, always < dvs so W bits suffice
    logic [ITER-1:0] dq;       // dividend bits shift out the top, quotient bits shift in the bottom
    logic            neg_r;
    logic            a_neg_r;
    logic            dz_r;
    fx_t             result_r;
    logic            div_zero_r;
    logic            overflow_r;

    logic [W:0]      rem_sh;
    logic            ge;
    fx_t             sat_result;
    logic            sat_ovf;

    assign in_ready  = (state == S_IDLE) && en;
    assign out_valid = (state == S_DONE);
    assign result    = result_r;
    assign div_zero  = div_zero_r;
    assign overflow  = overflow_r;

    // With a zero divisor ge is always set; the quotient is garbage but the
    // FIX stage ignores it because dz_r selects the rail value.
    assign rem_sh = {rem, dq[ITER-1]};
    assign ge     = rem_sh >= {1'b0, dvs};

    fx_sat_round #(
        .QW (QBITS),
        .RB (RB)
    ) u_sat_round (
        .q        (dq),
        .neg      (neg_r),
        .a_neg    (a_neg_r),
        .dz       (dz_r),
        .result   (sat_result),
        .overflow (sat_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            dvs        <= '0;
            rem        <= '0;
            dq         <= '0;
            neg_r      <= 1'b0;
            a_neg_r    <= 1'b0;
            dz_r       <= 1'b0;
            result_r   <= '0;
            div_zero_r <= 1'b0;
            overflow_r <= 1'b0;
        end else if (en) begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        state   <= S_CALC;
                        cnt     <= '0;
                        rem     <= '0;
                        dvs     <= fx_mag(datab);
                        dq      <= {fx_mag(dataa), {(FRAC+RB){1'b0}}};
                        neg_r   <= dataa[W-1] ^ datab[W-1];
                        a_neg_r <= dataa[W-1];
                        dz_r    <= (datab == '0);
                    end
                end
                S_CALC: begin
                    // ITER iterations, then one more cycle to hand over to FIX so the
                    // latency stays fixed regardless of operand values.
                    if (cnt == LAST) begin
                        state <= S_FIX;
                    end else begin
                        rem <= ge ? W'(rem_sh - {1'b0, dvs}) : rem_sh[W-1:0];
                        dq  <= {dq[ITER-2:0], ge};
                        cnt <= cnt + CW'(1);
                    end
                end
                S_FIX: begin
                    result_r   <= sat_result;
                    div_zero_r <= dz_r;
                    overflow_r <= sat_ovf;
                    state      <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fx_div_27.sv
// Purpose    : directed self-checking bench for fx_div_27 with hand-computed vectors.
// Latency    : checks the fixed accept-to-out_valid latency, plus stretching under en=0.
// Backpressure: checks result hold while out_ready=0 and in_ready return after handshake.
module tb_fx_div_27;

`ifdef FXDIV_ROUND_EN
    localparam int          EXP_LAT  = 38;
    localparam logic [26:0] EXP_2_3  = 27'h00000AB;
    localparam logic [26:0] EXP_HALF = 27'h0000001;
    localparam logic [26:0] EXP_NHALF = 27'h7FFFFFF;
`else
    localparam int          EXP_LAT  = 37;
    localparam logic [26:0] EXP_2_3  = 27'h00000AA;
    localparam logic [26:0] EXP_HALF = 27'h0000000;
    localparam logic [26:0] EXP_NHALF = 27'h0000000;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [26:0] dataa = '0;
    logic [26:0] datab = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [26:0] result;
    logic        div_zero;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fx_div_27 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dataa     (dataa),
        .datab     (datab),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .div_zero  (div_zero),
        .overflow  (overflow)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one operation, measure latency (edges after accept), optionally drop en for
    // 5 cycles after edge gap_at, hold out_ready low for bp cycles, then complete the handshake.
    task automatic do_op(input string tag, input logic [26:0] a, input logic [26:0] b,
                         input logic [26:0] er, input logic edz, input logic eov,
                         input int gap_at, input int bp);
        int  n;
        bit  seen;
        @(negedge clk);
        dataa    = a;
        datab    = b;
        in_valid = 1'b1;
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (gap_at > 0 && n == gap_at)     en = 1'b0;
            if (gap_at > 0 && n == gap_at + 5) en = 1'b1;
            if (out_valid) seen = 1'b1;
        end
        check({tag, " latency"}, 64'(n), 64'(EXP_LAT + ((gap_at > 0) ? 5 : 0)));
        for (int i = 0; i < bp; i++) begin
            @(posedge clk);
            #1;
        end
        if (bp > 0) begin
            check({tag, " bp out_valid"}, 64'(out_valid), 64'd1);
            check({tag, " bp in_ready"}, 64'(in_ready), 64'd0);
        end
        check({tag, " result"}, 64'(result), 64'(er));
        check({tag, " div_zero"}, 64'(div_zero), 64'(edz));
        check({tag, " overflow"}, 64'(overflow), 64'(eov));
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({tag, " post out_valid"}, 64'(out_valid), 64'd0);
        check({tag, " post in_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst result", 64'(result), 64'd0);
        check("rst div_zero", 64'(div_zero), 64'd0);
        check("rst overflow", 64'(overflow), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle in_ready", 64'(in_ready), 64'd1);
        en = 1'b0;
        #1 check("idle en0 in_ready", 64'(in_ready), 64'd0);
        en = 1'b1;

        // Main function
        do_op("3/2",      27'h0000300, 27'h0000200, 27'h0000180, 1'b0, 1'b0, 0, 0);
        do_op("-1/3",     27'h7FFFF00, 27'h0000300, 27'h7FFFFAB, 1'b0, 1'b0, 0, 0);
        do_op("2/3",      27'h0000200, 27'h0000300, EXP_2_3,     1'b0, 1'b0, 0, 0);
        do_op("half",     27'h0000001, 27'h0000200, EXP_HALF,    1'b0, 1'b0, 0, 0);
        do_op("nhalf",    27'h7FFFFFF, 27'h0000200, EXP_NHALF,   1'b0, 1'b0, 0, 0);
        do_op("0/3",      27'h0000000, 27'h0000300, 27'h0000000, 1'b0, 1'b0, 0, 0);

        // Divide by zero and saturation boundaries
        do_op("5/0",      27'h0000500, 27'h0000000, 27'h3FFFFFF, 1'b1, 1'b0, 0, 0);
        do_op("-5/0",     27'h7FFFB00, 27'h0000000, 27'h4000000, 1'b1, 1'b0, 0, 0);
        do_op("max/lsb",  27'h3FFFFFF, 27'h0000001, 27'h3FFFFFF, 1'b0, 1'b1, 0, 0);
        do_op("min/lsb",  27'h4000000, 27'h0000001, 27'h4000000, 1'b0, 1'b1, 0, 0);
        do_op("min/1",    27'h4000000, 27'h0000100, 27'h4000000, 1'b0, 1'b0, 0, 0);
        do_op("max/1",    27'h3FFFFFF, 27'h0000100, 27'h3FFFFFF, 1'b0, 1'b0, 0, 0);
        do_op("min/-1",   27'h4000000, 27'h7FFFF00, 27'h3FFFFFF, 1'b0, 1'b1, 0, 0);

        // Backpressure and enable stall
        do_op("bp",       27'h0000300, 27'h0000200, 27'h0000180, 1'b0, 1'b0, 0, 10);
        do_op("en gap",   27'h7FFFF00, 27'h0000300, 27'h7FFFFAB, 1'b0, 1'b0, 10, 0);

        // Reset mid-CALC: previous result is nonzero, so the clear is observable
        @(negedge clk);
        dataa    = 27'h0000300;
        datab    = 27'h0000200;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("midrst out_valid", 64'(out_valid), 64'd0);
        check("midrst result", 64'(result), 64'd0);
        check("midrst in_ready", 64'(in_ready), 64'd1);
        do_op("1/1",      27'h0000100, 27'h0000100, 27'h0000100, 1'b0, 1'b0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fx_div_27.md
Name: fx_div_27

Overview:
Iterative signed fixed-point divider, the inverse operation of the mat_mult multiplier array. Operand and result format match the array: 27-bit two's complement with 8 fractional bits. It computes result = (dataa << 8) / datab with rounding and saturation, one radix-2 quotient bit per enabled cycle. It sits in rtl/mat_mult beside the multiplier array and serves normalisation and pivot-division steps, using valid/ready handshakes on both sides.

Parameters:
- W, 27, operand/result width in bits.
- FRAC, 8, fractional bits; dividend is pre-shifted left by FRAC.
- QBITS, W+FRAC, integer quotient bits produced by the iteration (35).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  clock enable; 0 freezes all state.
- in_valid  in  1  operands valid.
- in_ready  out  1  block idle and able to accept.
- dataa  in  W  dividend, signed Q18.8.
- datab  in  W  divisor, signed Q18.8.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- result  out  W  quotient, signed Q18.8.
- div_zero  out  1  datab was 0; qualified by out_valid.
- overflow  out  1  quotient saturated; qualified by out_valid.

Behaviour:
- Reset (async, rst_n=0): state IDLE; out_valid=0, result=0, div_zero=0, overflow=0. in_ready=1 once rst_n=1 and en=1.
- in_ready = (state==IDLE) && en. Combinational from state; never from in_valid.
- Accept occurs when in_valid && in_ready at a clk edge. Operand magnitudes, result sign (sign_a XOR sign_b) and the zero-divisor flag are captured.
- FSM states and transitions:
  - IDLE -> CALC on accept.
  - CALC runs ITER enabled cycles, one bit per cycle: shift partial remainder, compare with |datab|, subtract if greater or equal. It then moves to FIX.
  - FIX (1 cycle) rounds, saturates, applies sign, and registers result and flags. It then moves to DONE.
  - DONE holds out_valid=1 and goes to IDLE on out_ready.
- ITER = QBITS+1 = 36 with rounding, QBITS = 35 without.
- Latency: accept at edge T gives out_valid=1 after edge T+ITER+2 (38 enabled cycles with rounding). Latency is constant, including divide-by-zero.
- No overlap: at most one operation in flight. After an out_ready handshake, in_ready returns the next cycle.
- Backpressure: while out_valid && !out_ready, result and flags are held stable.
- Rounding: round half away from zero, applied to the magnitude using the extra quotient bit, then the sign is applied.
- Saturation: positive magnitude > 2^26-1 gives 0x3FFFFFF; negative magnitude > 2^26 gives 0x4000000. Either case sets overflow=1.
- Divide by zero (datab==0): result = dataa>=0 ? 0x3FFFFFF : 0x4000000; div_zero=1, overflow=0.
- dataa==0 with datab≠0: result=0, no flags.
- Most-negative operand 0x4000000: its magnitude 2^26 is held in W+1 bits, so there is no internal overflow.
- en=0: no register changes in any state; out_valid stays as is.
- Reset mid-operation: immediate abort to IDLE; the partial result is discarded.

Optional Feature:
- Macro FXDIV_ROUND_EN.
- Defined: ITER=36, round half away from zero as above.
- Undefined: ITER=35, truncation toward zero, latency reduced by one cycle. Saturation and div-by-zero behaviour are unchanged.

Decomposition:
- Package fx_pkg holds:
  - FX_W=27, FX_FRAC=8;
  - FX_MAX=27'h3FFFFFF, FX_MIN=27'h4000000;
  - typedef fx_t (logic signed [26:0]);
  - enum fxdiv_state_t {IDLE, CALC, FIX, DONE}.
- One sub-module, fx_sat_round: combinational rounding, sign application and saturation, used in FIX. It is reusable by the multiplier path.

Test Plan:
- 3.0/2.0: dataa=0x300, datab=0x200 -> result=0x180, flags 0, out_valid exactly 38 enabled cycles after accept.
- -1.0/3.0: dataa=0x7FFFF00, datab=0x300 -> result=0x7FFFFAB (-85), flags 0.
- 2.0/3.0: dataa=0x200, datab=0x300 -> 0x0AB with FXDIV_ROUND_EN, 0x0AA without.
- Divide by zero and overflow:
  - 0x500/0 -> 0x3FFFFFF, div_zero=1;
  - 0x7FFFB00/0 -> 0x4000000, div_zero=1;
  - 0x3FFFFFF/0x001 -> 0x3FFFFFF, overflow=1.
- Backpressure and enable: hold out_ready=0 for 10 cycles -> result stable, in_ready=0. Toggle en low for 5 cycles mid-CALC -> latency extends by exactly 5 and the result is unchanged.
- Reset mid-CALC: pulse rst_n low for 1 cycle at iteration 10 -> out_valid=0, result=0, in_ready=1. A following 1.0/1.0 (0x100/0x100) gives 0x100.
